// File: rtl/psram_wb_arbiter_pkg.sv
// Shared types and constants for the two-master PSRAM Wishbone arbiter.
// PSRAM_ARB_TIMEOUT_EN selects the optional busy-timeout release path in the top.
package psram_arb_pkg;

  typedef enum logic [0:0] {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_t;

  localparam logic OWN_M0 = 1'b0;
  localparam logic OWN_M1 = 1'b1;

  localparam int DEF_TIMEOUT_CYCLES = 4096;

endpackage

// File: rtl/psram_wb_arbiter_if.sv
// Classic Wishbone link: the master modport drives the request, the slave modport answers.
interface psram_wb_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          cyc;
  logic          stb;
  logic          we;
  logic [AW-1:0] adr;
  logic [DW-1:0] dat_w;
  logic [3:0]    sel;
  logic [DW-1:0] dat_r;
  logic          ack;
  logic          err;

  modport master (
    output cyc, stb, we, adr, dat_w, sel,
    input  dat_r, ack
  );

  modport slave (
    input  cyc, stb, we, adr, dat_w, sel,
    output dat_r, ack, err
  );
endinterface

// File: rtl/psram_wb_arbiter_rr.sv
// Two-way round-robin picker: a lone request wins, a tie goes to the master not served last.
module psram_arb_rr (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt
);

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_pick
      assign gnt[gi] = req[gi] & (~req[1-gi] | (last != 1'(gi)));
    end
  endgenerate

endmodule

// File: rtl/psram_wb_arbiter.sv
// Arbitrates m0 (CPU) and m1 (DMA) onto the single PSRAM controller port, holding the latched
// request until ack. Define PSRAM_ARB_TIMEOUT_EN to add the forced-release busy timer.
module psram_wb_arbiter
  import psram_arb_pkg::*;
#(
  parameter int AW             = 32,
  parameter int DW             = 32,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic           clk,
  input  logic           rst_n,
  psram_wb_if.slave      m0,
  psram_wb_if.slave      m1,
  psram_wb_if.master     s
);

  arb_state_t    state_reg;
  logic          last_reg;
  logic          owner_reg;
  logic          aborted_reg;
  logic          we_reg;
  logic [AW-1:0] adr_reg;
  logic [DW-1:0] dat_reg;
  logic [3:0]    sel_reg;

  logic [1:0]    req;
  logic [1:0]    gnt;
  logic          busy;
  logic          owner_cyc;
  logic          ack_hit;
  logic          timeout_hit;
  logic          release_bus;

  assign req       = {m1.cyc & m1.stb, m0.cyc & m0.stb};
  assign busy      = (state_reg == ARB_BUSY);
  assign owner_cyc = (owner_reg == OWN_M1) ? m1.cyc : m0.cyc;

  // A master that let go of cyc since its grant does not see the controller's ack.
  assign ack_hit   = busy & s.ack & owner_cyc & ~aborted_reg;

  psram_arb_rr u_rr (
    .req  (req),
    .last (last_reg),
    .gnt  (gnt)
  );

`ifdef PSRAM_ARB_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [TW-1:0] timer_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_reg <= '0;
    end else if (!busy) begin
      timer_reg <= '0;
    end else begin
      timer_reg <= timer_reg + 1'b1;
    end
  end

  // An ack landing on the final timer cycle takes priority over the timeout.
  assign timeout_hit = busy & ~s.ack & (timer_reg == TW'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_hit = 1'b0;
`endif

  assign release_bus = busy & (s.ack | timeout_hit);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ARB_IDLE;
      last_reg    <= OWN_M1;
      owner_reg   <= OWN_M0;
      aborted_reg <= 1'b0;
      we_reg      <= 1'b0;
      adr_reg     <= '0;
      dat_reg     <= '0;
      sel_reg     <= '0;
    end else begin
      case (state_reg)
        ARB_IDLE: begin
          if (|gnt) begin
            state_reg   <= ARB_BUSY;
            owner_reg   <= gnt[1] ? OWN_M1 : OWN_M0;
            aborted_reg <= 1'b0;
            we_reg      <= gnt[1] ? m1.we    : m0.we;
            adr_reg     <= gnt[1] ? m1.adr   : m0.adr;
            dat_reg     <= gnt[1] ? m1.dat_w : m0.dat_w;
            sel_reg     <= gnt[1] ? m1.sel   : m0.sel;
          end
        end
        ARB_BUSY: begin
          if (release_bus) begin
            state_reg <= ARB_IDLE;
            last_reg  <= owner_reg;
          end else if (!owner_cyc) begin
            aborted_reg <= 1'b1;
          end
        end
        default: state_reg <= ARB_IDLE;
      endcase
    end
  end

  assign s.cyc   = busy;
  assign s.stb   = busy;
  assign s.we    = we_reg;
  assign s.adr   = adr_reg;
  assign s.dat_w = dat_reg;
  assign s.sel   = sel_reg;

  assign m0.dat_r = s.dat_r;
  assign m1.dat_r = s.dat_r;
  assign m0.ack   = ack_hit & (owner_reg == OWN_M0);
  assign m1.ack   = ack_hit & (owner_reg == OWN_M1);
  assign m0.err   = timeout_hit & (owner_reg == OWN_M0);
  assign m1.err   = timeout_hit & (owner_reg == OWN_M1);

endmodule

// File: tb/tb_psram_wb_arbiter.sv
// Directed scoreboard bench for psram_wb_arbiter; the timeout steps run when
// PSRAM_ARB_TIMEOUT_EN is defined (DUT built with TIMEOUT_CYCLES=16).
module tb_psram_wb_arbiter;

  logic clk = 1'b0;
  logic rst_n;

  psram_wb_if #(.AW(32), .DW(32)) m0_bus ();
  psram_wb_if #(.AW(32), .DW(32)) m1_bus ();
  psram_wb_if #(.AW(32), .DW(32)) s_bus ();

  psram_wb_arbiter #(
    .AW             (32),
    .DW             (32),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .m0    (m0_bus),
    .m1    (m1_bus),
    .s     (s_bus)
  );

  always #5 clk = ~clk;

`ifdef PSRAM_ARB_TIMEOUT_EN
  localparam int T1_WAIT = 10;
`else
  localparam int T1_WAIT = 20;
`endif

  typedef struct {
    logic        id;
    logic [31:0] dat;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_m(input logic id, input logic we, input logic [31:0] adr,
                         input logic [31:0] dat, input logic [3:0] sel);
    if (id) begin
      m1_bus.we = we; m1_bus.adr = adr; m1_bus.dat_w = dat; m1_bus.sel = sel;
      m1_bus.cyc = 1'b1; m1_bus.stb = 1'b1;
    end else begin
      m0_bus.we = we; m0_bus.adr = adr; m0_bus.dat_w = dat; m0_bus.sel = sel;
      m0_bus.cyc = 1'b1; m0_bus.stb = 1'b1;
    end
  endtask

  task automatic drop_m(input logic id);
    if (id) begin
      m1_bus.cyc = 1'b0; m1_bus.stb = 1'b0;
    end else begin
      m0_bus.cyc = 1'b0; m0_bus.stb = 1'b0;
    end
  endtask

  task automatic slave_ack(input logic [31:0] d);
    s_bus.dat_r = d;
    s_bus.ack   = 1'b1;
    tick();
    s_bus.ack   = 1'b0;
  endtask

  task automatic expect_ack(input logic id, input logic [31:0] d);
    exp_t e;
    e.id  = id;
    e.dat = d;
    exp_q.push_back(e);
  endtask

  // Ack monitor: every master ack must match the head of the scoreboard.
  always @(negedge clk) begin
    if (m0_bus.ack || m1_bus.ack) begin
      if (exp_q.size() == 0) begin
        chk("stray_ack", {30'd0, m1_bus.ack, m0_bus.ack}, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("dual_ack", {31'd0, m0_bus.ack & m1_bus.ack}, 32'd0);
        chk("ack_owner", {31'd0, m1_bus.ack}, {31'd0, e.id});
        chk("ack_dat", e.id ? m1_bus.dat_r : m0_bus.dat_r, e.dat);
        $display("ack m%0d dat=0x%08h (expected m%0d 0x%08h)", m1_bus.ack, 
                 m1_bus.ack ? m1_bus.dat_r : m0_bus.dat_r, e.id, e.dat);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    m0_bus.cyc = 1'b0; m0_bus.stb = 1'b0; m0_bus.we = 1'b0;
    m0_bus.adr = '0; m0_bus.dat_w = '0; m0_bus.sel = '0;
    m1_bus.cyc = 1'b0; m1_bus.stb = 1'b0; m1_bus.we = 1'b0;
    m1_bus.adr = '0; m1_bus.dat_w = '0; m1_bus.sel = '0;
    s_bus.dat_r = '0; s_bus.ack = 1'b0; s_bus.err = 1'b0;

    // Reset state
    #12;
    chk("rst_cyc", {31'd0, s_bus.cyc}, 32'd0);
    chk("rst_stb", {31'd0, s_bus.stb}, 32'd0);
    chk("rst_adr", s_bus.adr, 32'd0);
    chk("rst_acks", {30'd0, m1_bus.ack, m0_bus.ack}, 32'd0);
    tick();
    rst_n = 1'b1;

    // Stray ack in IDLE right after reset
    slave_ack(32'hA5A5_A5A5);
    chk("idle_ack_cyc", {31'd0, s_bus.cyc}, 32'd0);
    tick();
    chk("idle_ack_cyc2", {31'd0, s_bus.cyc}, 32'd0);

    // Single m0 read
    drive_m(1'b0, 1'b0, 32'h0000_0100, 32'h0, 4'hF);
    chk("rd_pre_grant_cyc", {31'd0, s_bus.cyc}, 32'd0);
    tick();
    chk("rd_cyc", {31'd0, s_bus.cyc}, 32'd1);
    chk("rd_adr", s_bus.adr, 32'h0000_0100);
    chk("rd_we", {31'd0, s_bus.we}, 32'd0);
    repeat (T1_WAIT - 1) tick();
    chk("rd_hold_cyc", {31'd0, s_bus.cyc}, 32'd1);
    expect_ack(1'b0, 32'hDEAD_BEEF);
    slave_ack(32'hDEAD_BEEF);
    drop_m(1'b0);
    chk("rd_release_cyc", {31'd0, s_bus.cyc}, 32'd0);
    tick();

    // m1 write with address change mid-BUSY
    drive_m(1'b1, 1'b1, 32'h0000_0010, 32'h0000_1234, 4'b0011);
    tick();
    chk("wr_cyc", {31'd0, s_bus.cyc}, 32'd1);
    chk("wr_we", {31'd0, s_bus.we}, 32'd1);
    chk("wr_dat", s_bus.dat_w, 32'h0000_1234);
    m1_bus.adr = 32'h0000_0020; m1_bus.sel = 4'b1100; m1_bus.dat_w = 32'h0000_5678;
    repeat (3) tick();
    chk("wr_hold_adr", s_bus.adr, 32'h0000_0010);
    chk("wr_hold_sel", {28'd0, s_bus.sel}, 32'h3);
    chk("wr_hold_dat", s_bus.dat_w, 32'h0000_1234);
    expect_ack(1'b1, 32'h0000_0000);
    slave_ack(32'h0000_0000);
    drop_m(1'b1);
    tick();

    // Tie: m0 first, one IDLE cycle, then m1; the next tie goes to m0 again
    for (int round = 0; round < 2; round++) begin
      drive_m(1'b0, 1'b0, 32'h0000_0200, 32'h0, 4'hF);
      drive_m(1'b1, 1'b0, 32'h0000_0300, 32'h0, 4'hF);
      tick();
      chk("tie_first_adr", s_bus.adr, 32'h0000_0200);
      tick();
      expect_ack(1'b0, 32'h1111_0000 + 32'(round));
      slave_ack(32'h1111_0000 + 32'(round));
      drop_m(1'b0);
      chk("tie_gap_cyc", {31'd0, s_bus.cyc}, 32'd0);
      tick();
      chk("tie_second_cyc", {31'd0, s_bus.cyc}, 32'd1);
      chk("tie_second_adr", s_bus.adr, 32'h0000_0300);
      expect_ack(1'b1, 32'h2222_0000 + 32'(round));
      slave_ack(32'h2222_0000 + 32'(round));
      drop_m(1'b1);
      tick();
    end

    // m0 aborts 3 cycles after grant; pending m1 is served next
    drive_m(1'b0, 1'b0, 32'h0000_0400, 32'h0, 4'hF);
    drive_m(1'b1, 1'b0, 32'h0000_0500, 32'h0, 4'hF);
    tick();
    chk("abort_adr", s_bus.adr, 32'h0000_0400);
    repeat (3) tick();
    drop_m(1'b0);
    repeat (2) tick();
    chk("abort_hold_cyc", {31'd0, s_bus.cyc}, 32'd1);
    slave_ack(32'h3333_3333);
    chk("abort_idle_cyc", {31'd0, s_bus.cyc}, 32'd0);
    tick();
    chk("abort_next_adr", s_bus.adr, 32'h0000_0500);
    expect_ack(1'b1, 32'h4444_4444);
    slave_ack(32'h4444_4444);
    drop_m(1'b1);
    tick();

`ifdef PSRAM_ARB_TIMEOUT_EN
    // Slave never acks: err in BUSY cycle 16, then next request granted
    drive_m(1'b0, 1'b0, 32'h0000_0600, 32'h0, 4'hF);
    tick();
    chk("to_c1_err", {31'd0, m0_bus.err}, 32'd0);
    repeat (14) tick();
    chk("to_c15_err", {31'd0, m0_bus.err}, 32'd0);
    tick();
    chk("to_c16_err", {31'd0, m0_bus.err}, 32'd1);
    chk("to_c16_m1err", {31'd0, m1_bus.err}, 32'd0);
    chk("to_c16_stb", {31'd0, s_bus.stb}, 32'd1);
    drop_m(1'b0);
    drive_m(1'b1, 1'b0, 32'h0000_0700, 32'h0, 4'hF);
    tick();
    chk("to_drop_stb", {31'd0, s_bus.stb}, 32'd0);
    chk("to_err_pulse", {31'd0, m0_bus.err}, 32'd0);
    tick();
    chk("to_next_adr", s_bus.adr, 32'h0000_0700);
`else
    drive_m(1'b1, 1'b0, 32'h0000_0700, 32'h0, 4'hF);
    tick();
    chk("mid_busy_adr", s_bus.adr, 32'h0000_0700);
`endif

    // Asynchronous reset in the middle of BUSY
    #3;
    rst_n = 1'b0;
    #1;
    chk("arst_cyc", {31'd0, s_bus.cyc}, 32'd0);
    chk("arst_adr", s_bus.adr, 32'd0);
    chk("arst_acks", {30'd0, m1_bus.ack, m0_bus.ack}, 32'd0);
    drop_m(1'b1);
    tick();
    rst_n = 1'b1;
    slave_ack(32'h5555_5555);
    chk("post_rst_cyc", {31'd0, s_bus.cyc}, 32'd0);
    tick();

    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
